lsu: RTL
========

# lsu

Load/store unit for the RV32I core: the execution-side responder to the decoder's memory command (`L`, `wmem`, `mem_len`, `mem_sign`). It accepts one load or store per handshake, checks alignment, and drives a single-outstanding request/grant/response data-memory bus with byte enables and lane replication. It returns aligned, sign- or zero-extended load data, or a misalignment exception for the trap logic, to the writeback stage.

## Interface
- No parameters; the data and address width is fixed at 32.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  LSU is in IDLE and can accept a command.
- `in_load`  in  1  load command (decoder `L`).
- `in_store`  in  1  store command (decoder `wmem`).
- `in_len`  in  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- `in_sign`  in  1  sign-extend load data.
- `in_addr`  in  32  effective byte address.
- `in_wdata`  in  32  store data (rs2).
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  write request.
- `mem_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  32  read word.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  load result, valid when `done` is high.
- `exc_load_misaligned`  out  1  pulses together with `done`.
- `exc_store_misaligned`  out  1  pulses together with `done`.
- `exc_addr`  out  32  faulting byte address (for mtval), valid with an exception.

## Operation
- The FSM has four states: IDLE, REQ, RESP and DONE.
- **Accept.** A command is accepted when `in_valid & in_ready`. All inputs are registered at acceptance, and input values outside acceptance are ignored.
- **Load/store priority.** If `in_load` and `in_store` are both set, the command is a load. If neither is set, the command is a no-op: IDLE→DONE with `rdata = 0` and no bus activity.
- **Misalignment.** A half access with `addr[0]=1` or a word access with `addr[1:0]≠0` is misaligned. Misaligned commands go IDLE→DONE with the matching `exc_*` bit set, `exc_addr` set to the address, and no bus request.
- **Aligned accesses.** An aligned command goes IDLE→REQ.
  - In REQ, `mem_req=1` and the bus outputs are held stable until `mem_gnt`.
  - A store with `mem_gnt` goes REQ→DONE.
  - A load with `mem_gnt` goes REQ→RESP.
  - In RESP, the LSU waits for `mem_rvalid`. When it arrives, `rdata` is captured and the FSM goes RESP→DONE.
  - `mem_rvalid` in the same cycle as `mem_gnt` is not permitted by the bus.
- **DONE.** `done=1` for exactly one cycle, then the FSM returns to IDLE.
- **Store lanes.**
  - Byte: `mem_wdata={4{wdata[7:0]}}`, `mem_be=4'b0001<<addr[1:0]`.
  - Half: `mem_wdata={2{wdata[15:0]}}`, `mem_be=addr[1]?4'b1100:4'b0011`.
  - Word: `mem_wdata=wdata`, `mem_be=4'b1111`.
- **Load extraction.** The read word is shifted as `mem_rdata >> (8*addr[1:0])`. The low 8 or 16 bits are then extended: sign-extended if `in_sign`, else zero-extended. Word loads pass through.
- **Idle bus outputs.** `mem_we`, `mem_be` and `mem_wdata` are 0 whenever `mem_req=0`.

## Timing
- **Reset values.**
  - All outputs are 0 except `in_ready=1`.
  - `rdata`, `exc_addr` = 0.
  - FSM = IDLE.
- **Latency from accept edge.**
  - Misaligned or no-op: `done` in the next cycle.
  - Store with immediate grant: `mem_req` in cycle +1, `done` in cycle +2.
  - Load with immediate grant and rvalid one cycle after grant: `done` in cycle +3.
  - Each additional cycle of grant or response wait adds one cycle.
- **Back-to-back.** `in_ready` is low from the cycle after accept through the DONE cycle. The next accept is possible in the cycle after `done`, giving a minimum of 2 cycles per command.
- **Reset mid-operation.** Reset forces IDLE on the next edge. `mem_req` drops and no `done` pulse is produced. A stale `mem_rvalid` arriving in IDLE is ignored.
- **Held outputs.** `rdata` and `exc_addr` hold their values after `done` until the next completion. The `exc_*` bits are pulses.

## Structure
- Shared package `rv32i_pkg` holds:
  - `mem_len` encodings: `MEM_B=2'd0`, `MEM_H=2'd1`, `MEM_W=2'd2`.
  - FSM state encodings: `LSU_IDLE`, `LSU_REQ`, `LSU_RESP`, `LSU_DONE`.
  - The decoder uses the same `mem_len` constants.
- One combinational sub-module, `lsu_align`, computes store lane replication and byte enables, the misalignment flag, and load extraction/extension. The FSM and registers live in `lsu`.

## Test plan
- **Word store.** SW `addr=0x104`, `wdata=0xDEADBEEF`, `gnt` held low for 2 cycles → `mem_req` held 3 cycles with `mem_addr=0x104`, `be=1111`, `we=1`; `done` the cycle after `gnt`; no exception.
- **Signed and unsigned byte loads.** LB `addr=0x203` with `mem_rdata=0x80FF_1234` → `rdata=0xFFFFFF80`, `be=1000`. LBU at the same address → `rdata=0x00000080`.
- **Half store and half load.** SH `addr=0x22`, `wdata=0x0000ABCD` → `mem_wdata=0xABCDABCD`, `be=1100`. LH `addr=0x22` with `rdata=0xABCD0000` → `rdata=0xFFFFABCD`.
- **Misaligned access.** LW `addr=0x101` → no `mem_req`, `done` next cycle with `exc_load_misaligned=1` and `exc_addr=0x101`. SH `addr=0x3` → `exc_store_misaligned=1`.
- **Reset during RESP.** Assert `rst` while waiting for `rvalid`, then pulse `rvalid` → FSM in IDLE, `in_ready=1`, no `done`, `rdata=0`.
- **Back-to-back commands.** Hold `in_valid` high with two stores → second accept occurs in the cycle after the first `done`; `in_ready` is never high while busy.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core types: memory access sizes, LSU states
// and the command bundle latched by the load/store unit.
package rv32i_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_RESP,
    LSU_DONE
  } lsu_state_e;

  typedef struct packed {
    logic        load;
    logic        store;
    logic [1:0]  len;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_cmd_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath for the LSU: store replication and enables,
// alignment check and load extraction/extension.
module lsu_align
  import rv32i_pkg::*;
(
  input  logic [1:0]  len,
  input  logic [1:0]  addr_lo,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misaligned,
  output logic [31:0] ld_data
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [31:0] sh;

  // len 3 falls into the word group
  assign is_b = (len == MEM_B);
  assign is_h = (len == MEM_H);
  assign is_w = len[1];

  assign misaligned = (is_h & addr_lo[0]) |
                      (is_w & (|addr_lo));

  assign sh = rdata >> {addr_lo, 3'b000};

  always_comb begin
    be        = 4'b0000;
    wdata_rep = '0;
    ld_data   = '0;
    unique case (1'b1)
      is_b: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        ld_data   = sign ? {{24{sh[7]}}, sh[7:0]}
                         : {24'd0, sh[7:0]};
      end
      is_h: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        ld_data   = sign ? {{16{sh[15]}}, sh[15:0]}
                         : {16'd0, sh[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        ld_data   = rdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one command at a time over a
// single-outstanding req/gnt/rvalid data bus.
module lsu
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [1:0]  in_len,
  input  logic        in_sign,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        exc_load_misaligned,
  output logic        exc_store_misaligned,
  output logic [31:0] exc_addr
);

  lsu_state_e  state_q;
  lsu_state_e  state_d;
  lsu_cmd_t    cmd_q;
  logic [31:0] rdata_q;
  logic [31:0] exc_addr_q;
  logic        el_q;
  logic        es_q;

  logic        idle;
  logic        accept;
  logic        is_st;
  logic        noop;
  logic [1:0]  a_len;
  logic [1:0]  a_addr;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic        al_mis;
  logic [31:0] al_ld;

  assign idle   = (state_q == LSU_IDLE);
  assign accept = in_valid & idle;
  assign is_st  = in_store & ~in_load;
  assign noop   = ~(in_load | in_store);

  // alignment is judged on the live command while idle
  assign a_len  = idle ? in_len       : cmd_q.len;
  assign a_addr = idle ? in_addr[1:0] : cmd_q.addr[1:0];

  lsu_align u_align (
    .len        (a_len),
    .addr_lo    (a_addr),
    .sign       (cmd_q.sign),
    .wdata      (cmd_q.wdata),
    .rdata      (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .misaligned (al_mis),
    .ld_data    (al_ld)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          state_d = (noop | al_mis) ? LSU_DONE : LSU_REQ;
        end
      end
      LSU_REQ: begin
        if (mem_gnt) begin
          state_d = cmd_q.store ? LSU_DONE : LSU_RESP;
        end
      end
      LSU_RESP: begin
        if (mem_rvalid) state_d = LSU_DONE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LSU_IDLE;
      cmd_q      <= '0;
      rdata_q    <= '0;
      exc_addr_q <= '0;
      el_q       <= 1'b0;
      es_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmd_q <= '{load:  in_load,
                   store: is_st,
                   len:   in_len,
                   sign:  in_sign,
                   addr:  in_addr,
                   wdata: in_wdata};
        el_q  <= in_load & al_mis;
        es_q  <= is_st & al_mis;
        if (~noop & al_mis) exc_addr_q <= in_addr;
        if (noop | al_mis)  rdata_q    <= '0;
      end
      if ((state_q == LSU_RESP) & mem_rvalid) begin
        rdata_q <= al_ld;
      end
    end
  end

  assign in_ready  = idle;
  assign mem_req   = (state_q == LSU_REQ);
  assign mem_we    = mem_req & cmd_q.store;
  assign mem_addr  = mem_req ? {cmd_q.addr[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? al_be : 4'b0000;
  assign mem_wdata = mem_we ? al_wdata : '0;

  assign done                 = (state_q == LSU_DONE);
  assign rdata                = rdata_q;
  assign exc_load_misaligned  = done & el_q;
  assign exc_store_misaligned = done & es_q;
  assign exc_addr             = exc_addr_q;

endmodule
